// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer.
// FETCH_WIDTH (instructions per group) may be supplied by the build; 2 gives 8-byte groups.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

package fetch_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam int unsigned FETCH_GROUP_BYTES = `FETCH_WIDTH * 4;

endpackage

// File: rtl/fetch_ctrl_updown_cnt.sv
// Saturating up/down counter with synchronous clear and parallel load.
module updown_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !dec && cnt != MAX_V) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues group-aligned I-cache requests under buffer credit,
// discards responses made stale by a redirect, and drives instr_buf controls.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          GROUP_BYTES  = FETCH_GROUP_BYTES,
  parameter int unsigned          BUF_GROUPS   = 4,
  parameter int unsigned          MAX_INFLIGHT = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_redirect,
  input  logic [PC_WIDTH-1:0] i_redirect_pc,
  output logic                o_req_valid,
  output logic [PC_WIDTH-1:0] o_req_pc,
  input  logic                i_req_ready,
  input  logic                i_resp_valid,
  input  logic                i_resp_fault,
  output logic                o_buf_push,
  output logic                o_buf_flush,
  input  logic                i_dec_ready,
  output logic                o_buf_dequeue
);

  localparam int unsigned OCC_W = $clog2(BUF_GROUPS + 1);
  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(GROUP_BYTES - 1));

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [OCC_W-1:0]    occ;
  logic [INF_W-1:0]    live;
  logic [INF_W-1:0]    drop;
  logic [INF_W-1:0]    drop_redirect;
  logic                has_credit;
  logic                has_slot;
  logic                resp_drop;
  logic                resp_keep;
  logic                accept;

  always_comb begin
    has_credit    = (32'(occ) + 32'(live)) < BUF_GROUPS;
    has_slot      = (32'(live) + 32'(drop)) < MAX_INFLIGHT;
    // Responses return in order, so stale ones always sit ahead of live ones.
    resp_drop     = i_resp_valid && (drop != '0);
    resp_keep     = i_resp_valid && (drop == '0);
    o_req_valid   = !i_rst && (state == RUN) && !i_redirect && has_credit && has_slot;
    o_req_pc      = i_rst ? '0 : pc;
    accept        = o_req_valid && i_req_ready;
    o_buf_push    = !i_rst && resp_keep && !i_redirect;
    o_buf_dequeue = !i_rst && i_dec_ready && !i_redirect;
    o_buf_flush   = !i_rst && i_redirect;
    // Every outstanding request turns stale; a response this cycle retires one of them.
    drop_redirect = drop + live - INF_W'(i_resp_valid);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
      pc    <= RESET_PC & ALIGN_MASK;
    end else if (i_redirect) begin
      state <= RUN;
      pc    <= i_redirect_pc & ALIGN_MASK;
    end else begin
      if (accept) pc <= pc + PC_WIDTH'(GROUP_BYTES);
      if (o_buf_push && i_resp_fault) state <= HALT;
    end
  end

  updown_cnt #(.MAX(BUF_GROUPS), .W(OCC_W)) u_occ (
    .clk(i_clk), .rst(i_rst), .clr(i_redirect), .load(1'b0), .load_val('0),
    .inc(o_buf_push), .dec(o_buf_dequeue), .cnt(occ)
  );

  updown_cnt #(.MAX(MAX_INFLIGHT), .W(INF_W)) u_live (
    .clk(i_clk), .rst(i_rst), .clr(i_redirect), .load(1'b0), .load_val('0),
    .inc(accept), .dec(resp_keep), .cnt(live)
  );

  updown_cnt #(.MAX(MAX_INFLIGHT), .W(INF_W)) u_drop (
    .clk(i_clk), .rst(i_rst), .clr(1'b0), .load(i_redirect), .load_val(drop_redirect),
    .inc(1'b0), .dec(resp_drop), .cnt(drop)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ((32'(occ) + 32'(live)) <= BUF_GROUPS);
      assert ((32'(live) + 32'(drop)) <= MAX_INFLIGHT);
      assert (!(o_buf_push && 32'(occ) == BUF_GROUPS));
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level model of requests, buffer fill and halt state.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int unsigned BUF_GROUPS   = 4;
  localparam int unsigned MAX_INFLIGHT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_req_valid;
  logic [31:0] o_req_pc;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic        i_resp_fault;
  logic        o_buf_push;
  logic        o_buf_flush;
  logic        i_dec_ready;
  logic        o_buf_dequeue;

  int checks   = 0;
  int failures = 0;

  // Model: one entry per outstanding request, 1 = response will be kept.
  bit          q[$];
  int          m_occ;
  logic [31:0] m_pc;
  bit          m_halted;

  fetch_ctrl #(
    .PC_WIDTH(32), .GROUP_BYTES(FETCH_GROUP_BYTES), .BUF_GROUPS(BUF_GROUPS),
    .MAX_INFLIGHT(MAX_INFLIGHT), .RESET_PC(32'h0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_req_valid(o_req_valid), .o_req_pc(o_req_pc), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_fault(i_resp_fault), .o_buf_push(o_buf_push),
    .o_buf_flush(o_buf_flush), .i_dec_ready(i_dec_ready), .o_buf_dequeue(o_buf_dequeue)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_occ    = 0;
    m_pc     = 32'h0;
    m_halted = 1'b0;
  endtask

  // One cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                      input bit rv, input bit flt, input bit dec);
    bit rvv, exp_v, exp_push, exp_deq;
    int nkeep;
    rvv = rv && (q.size() > 0);
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_req_ready   = rdy;
    i_resp_valid  = rvv;
    i_resp_fault  = flt;
    i_dec_ready   = dec;
    #1;
    nkeep = 0;
    foreach (q[k]) if (q[k]) nkeep++;
    exp_v    = !m_halted && !redir && (m_occ + nkeep < BUF_GROUPS) && (q.size() < MAX_INFLIGHT);
    exp_push = rvv && q[0] && !redir;
    exp_deq  = dec && !redir;
    check("req_valid", 32'(o_req_valid), 32'(exp_v));
    check("req_pc", o_req_pc, m_pc);
    check("buf_push", 32'(o_buf_push), 32'(exp_push));
    check("buf_dequeue", 32'(o_buf_dequeue), 32'(exp_deq));
    check("buf_flush", 32'(o_buf_flush), 32'(redir));
    if (rvv) void'(q.pop_front());
    if (redir) begin
      foreach (q[k]) q[k] = 1'b0;
      m_occ    = 0;
      m_pc     = rpc & ~(FETCH_GROUP_BYTES - 1);
      m_halted = 1'b0;
    end else begin
      if (exp_push && !exp_deq) m_occ++;
      else if (!exp_push && exp_deq && m_occ > 0) m_occ--;
      if (exp_push && flt) m_halted = 1'b1;
      if (exp_v && rdy) begin
        q.push_back(1'b1);
        m_pc = m_pc + FETCH_GROUP_BYTES;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_req_ready = 1'b1;
    i_resp_valid = 1'b0; i_resp_fault = 1'b0; i_dec_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_req_valid", 32'(o_req_valid), 32'h0);
    check("rst_req_pc", o_req_pc, 32'h0);
    check("rst_buf_push", 32'(o_buf_push), 32'h0);
    i_redirect = 1'b1; i_dec_ready = 1'b1; #1;
    check("rst_buf_flush", 32'(o_buf_flush), 32'h0);
    check("rst_buf_dequeue", 32'(o_buf_dequeue), 32'h0);
    i_rst = 1'b0; i_redirect = 1'b0;
    model_reset();

    // Streaming: one request per cycle, 1-cycle response latency.
    repeat (8) step(0, '0, 1, 1, 0, 1);

    // Buffer fill without decode, then drain.
    repeat (8) step(0, '0, 1, 1, 0, 0);
    repeat (8) step(0, '0, 1, 1, 0, 1);

    // Two outstanding, then redirect; both stale responses must be dropped.
    repeat (2) step(0, '0, 1, 0, 0, 1);
    step(1, 32'h1234, 1, 0, 0, 1);
    check("redir_pc", o_req_pc, 32'h1230);
    repeat (6) step(0, '0, 1, 1, 0, 1);

    // Faulting group halts issue until a redirect.
    step(0, '0, 1, 1, 1, 1);
    repeat (20) step(0, '0, 1, 1, 0, 1);
    step(1, 32'h100, 1, 1, 0, 1);
    step(0, '0, 1, 1, 0, 1);

    // Redirect, response and decode in the same cycle.
    repeat (3) step(0, '0, 1, 1, 0, 0);
    step(1, 32'h40, 1, 1, 0, 1);
    repeat (4) step(0, '0, 1, 1, 0, 0);

    // PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFFC, 1, 1, 0, 1);
    step(0, '0, 1, 1, 0, 1);
    check("wrap_pc", o_req_pc, 32'h0);
    repeat (4) step(0, '0, 1, 1, 0, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(15) == 0), $urandom, $urandom_range(1), ($urandom_range(9) < 6),
           ($urandom_range(15) == 0), $urandom_range(1));
    end

    // Reset mid-operation clears everything.
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_reset();
    repeat (30) step(($urandom_range(15) == 0), $urandom, $urandom_range(1), $urandom_range(1),
                     1'b0, $urandom_range(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the front end. It generates group-aligned fetch PCs toward the instruction cache and gates issue with a credit count that mirrors free space in `instr_buf`. It drops stale cache responses after a redirect and drives the buffer's push, dequeue and flush controls. It sits between the branch/commit redirect sources, the I-cache request port and `instr_buf`.

## Interface
- `PC_WIDTH`, 32, width of fetch and redirect PCs.
- `GROUP_BYTES`, `` `FETCH_WIDTH*4 ``, bytes per fetch group; a power of two.
- `BUF_GROUPS`, 4, capacity of `instr_buf` in groups (depth / `` `FETCH_WIDTH ``).
- `MAX_INFLIGHT`, 2, maximum I-cache requests outstanding.
- `RESET_PC`, 32'h0, first fetch address after reset.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_redirect`  in  1  redirect/flush request, one-cycle pulse.
- `i_redirect_pc`  in  `PC_WIDTH`  new fetch PC; low log2(`GROUP_BYTES`) bits ignored.
- `o_req_valid`  out  1  fetch request valid.
- `o_req_pc`  out  `PC_WIDTH`  group-aligned fetch PC.
- `i_req_ready`  in  1  I-cache accepts the request this cycle.
- `i_resp_valid`  in  1  I-cache returns one group, strictly in request order.
- `i_resp_fault`  in  1  the returned group faulted (qualified by `i_resp_valid`).
- `o_buf_push`  out  1  write the current response group into `instr_buf`.
- `o_buf_flush`  out  1  flush `instr_buf`.
- `i_dec_ready`  in  1  decode consumes one group this cycle.
- `o_buf_dequeue`  out  1  dequeue to `instr_buf`.

## Operation
- States:
  - RUN: issue enabled.
  - HALT: issue disabled after a faulting group is accepted.
- State transitions:
  - RUN→HALT on an accepted response with `i_resp_fault`=1.
  - HALT→RUN on `i_redirect`.
  - `i_redirect` in RUN stays in RUN.
- Counters, each of width $clog2(max+1):
  - `occ`: groups held in the buffer.
  - `live`: outstanding requests whose responses will be kept.
  - `drop`: outstanding requests whose responses will be discarded.
- Credit: `credits = BUF_GROUPS - occ - live`.
- Issue: `o_req_valid = RUN & ~i_redirect & credits>0 & (live+drop)<MAX_INFLIGHT`.
  - On acceptance (`o_req_valid & i_req_ready`): `live`+1 and `pc += GROUP_BYTES`.
  - `pc` wraps modulo 2^`PC_WIDTH`.
- Response handling:
  - If `drop`>0 and `i_resp_valid`: `drop`−1, the response is discarded, `o_buf_push`=0.
  - Otherwise `o_buf_push = i_resp_valid`, `live`−1 and `occ`+1.
- Dequeue: `o_buf_dequeue = i_dec_ready & ~i_redirect`.
  - `occ`−1 only if `occ`>0; a dequeue on an empty buffer is harmless.
- Redirect, same-cycle effects:
  - `o_buf_flush = i_redirect`.
  - `o_buf_push` is forced to 0; a response in the redirect cycle is discarded.
- Redirect, next-edge updates:
  - `pc ← i_redirect_pc & ~(GROUP_BYTES-1)`.
  - `occ ← 0`.
  - `drop ← drop + live − (response consumed this cycle)`; a request accepted this cycle cannot exist because issue is masked.
  - `live ← 0`.
- Simultaneous push and dequeue: `occ` unchanged.
- Invariants (assertion-checked):
  - `occ+live ≤ BUF_GROUPS`.
  - `live+drop ≤ MAX_INFLIGHT`.
  - `instr_buf` is never pushed while full.

## Timing
- Reset:
  - While `i_rst`=1, all outputs are 0.
  - After reset: `pc=RESET_PC`, state RUN, all counters 0.
  - First `o_req_valid`=1 in the first cycle with `i_rst`=0.
- Reset mid-operation: counters are cleared, and responses for pre-reset requests are the I-cache's responsibility (it is reset on the same `i_rst`).
- `o_req_valid`, `o_req_pc`, `o_buf_push`, `o_buf_dequeue` and `o_buf_flush` are combinational from registered state plus the same-cycle inputs.
- Redirect at cycle T: `o_buf_flush`=1 at T; first request with the new PC at T+1.
- Throughput: one request per cycle while credits and in-flight slots allow.

## Structure
- Shared package:
  - `fetch_state_t` enum (RUN, HALT).
  - `GROUP_BYTES` derivation from `` `FETCH_WIDTH ``.
- One sub-module is natural: `updown_cnt`, a saturating up/down counter with synchronous clear, instantiated for `occ`, `live` and `drop`.

## Test plan
- Reset, `i_req_ready`=1, 1-cycle response latency, `i_dec_ready`=1 → PCs 0x0, 0x8, 0x10, … on consecutive cycles; `o_buf_push` one cycle after each accept.
- `i_dec_ready`=0, `BUF_GROUPS`=4 → exactly 4 requests accepted, then `o_req_valid`=0; raising `i_dec_ready` resumes issue one group per dequeue.
- 2 requests outstanding, `i_redirect` with PC 0x1234 → `o_buf_flush`=1 same cycle; next request PC 0x1230; both stale responses give `o_buf_push`=0.
- Response carries `i_resp_fault`=1 → that group pushed, `o_req_valid` stays 0 for 20 cycles; `i_redirect` to 0x100 → request at 0x100 next cycle.
- Same-cycle `i_redirect`, `i_resp_valid` and `i_dec_ready` → no push, no dequeue, flush=1, and `occ`=0 in the next cycle.
- `pc`=0xFFFFFFF8 accepted → next `o_req_pc`=0x0.
